// File: rtl/load_store_unit.sv
// load_store_unit: RV32 data-memory access stage.
// Runs a req/ack transaction per load/store, formats store lanes and
// load sign/zero extension, and stalls the core until the access retires.
module load_store_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        stall,
    output logic [31:0] load_data,
    output logic        fault,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_wstrb,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata
);

    localparam int unsigned XLEN = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state;
    logic [2:0]        f3_q;
    logic [1:0]        off_q;

    logic              op;
    logic              illegal;
    logic              misaligned;
    logic              fault_raw;
    logic              accept;
    logic [XLEN-1:0]   st_wdata;
    logic [3:0]        st_wstrb;
    logic [7:0]        ld_byte;
    logic [15:0]       ld_half;
    logic [XLEN-1:0]   ld_fmt;

    // Access legality: illegal size encodings, misalignment, or read+write together
    always_comb begin
        op         = mem_read | mem_write;
        illegal    = 1'b0;
        misaligned = 1'b0;
        if (mem_write) begin
            illegal = (funct3 != 3'd0) && (funct3 != 3'd1) && (funct3 != 3'd2);
        end else begin
            illegal = (funct3 == 3'd3) || (funct3 == 3'd6) || (funct3 == 3'd7);
        end
        if (funct3[1:0] == 2'd1) begin
            misaligned = addr[0];
        end else if (funct3[1:0] == 2'd2) begin
            misaligned = (addr[1:0] != 2'b00);
        end
        fault_raw = op & ((mem_read & mem_write) | illegal | misaligned);
        accept    = (state == IDLE) & op & ~fault_raw;
        fault     = (state == IDLE) & fault_raw;
        stall     = (state == BUSY) | accept;
    end

    // Store lane replication and byte enables from the incoming address
    always_comb begin
        st_wdata = wdata;
        st_wstrb = 4'b1111;
        case (funct3[1:0])
            2'd0: begin
                st_wdata = {4{wdata[7:0]}};
                st_wstrb = 4'b0001 << addr[1:0];
            end
            2'd1: begin
                st_wdata = {2{wdata[15:0]}};
                st_wstrb = addr[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                st_wdata = wdata;
                st_wstrb = 4'b1111;
            end
        endcase
    end

    // Load lane select and extension using the latched size and offset
    always_comb begin
        ld_byte = dmem_rdata[{off_q, 3'b000} +: 8];
        ld_half = dmem_rdata[{off_q[1], 4'b0000} +: 16];
        case (f3_q)
            3'd0:    ld_fmt = {{24{ld_byte[7]}}, ld_byte};
            3'd1:    ld_fmt = {{16{ld_half[15]}}, ld_half};
            3'd4:    ld_fmt = {24'd0, ld_byte};
            3'd5:    ld_fmt = {16'd0, ld_half};
            default: ld_fmt = dmem_rdata;
        endcase
    end

    // Transaction FSM with registered memory-port outputs and load result
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            f3_q       <= 3'd0;
            off_q      <= 2'd0;
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_addr  <= 32'd0;
            dmem_wdata <= 32'd0;
            dmem_wstrb <= 4'd0;
            load_data  <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        f3_q       <= funct3;
                        off_q      <= addr[1:0];
                        dmem_req   <= 1'b1;
                        dmem_we    <= mem_write;
                        dmem_addr  <= {addr[31:2], 2'b00};
                        dmem_wdata <= mem_write ? st_wdata : 32'd0;
                        dmem_wstrb <= mem_write ? st_wstrb : 4'b0000;
                        state      <= BUSY;
                    end
                end
                BUSY: begin
                    if (dmem_ack) begin
                        dmem_req <= 1'b0;
                        if (!dmem_we) begin
                            load_data <= ld_fmt;
                        end
                        state <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state    <= IDLE;
                    dmem_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed vectors with hand-computed expectations.
module tb_load_store_unit;

    logic        clk;
    logic        rst;
    logic        mem_read;
    logic        mem_write;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        stall;
    logic [31:0] load_data;
    logic        fault;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_wstrb;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] cap_addr;
    logic [31:0] cap_wdata;
    logic [3:0]  cap_wstrb;
    logic        cap_we;
    logic        stable_ok;
    int          stall_cnt;

    load_store_unit dut (
        .clk        (clk),
        .rst        (rst),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .funct3     (funct3),
        .addr       (addr),
        .wdata      (wdata),
        .stall      (stall),
        .load_data  (load_data),
        .fault      (fault),
        .dmem_req   (dmem_req),
        .dmem_we    (dmem_we),
        .dmem_addr  (dmem_addr),
        .dmem_wdata (dmem_wdata),
        .dmem_wstrb (dmem_wstrb),
        .dmem_ack   (dmem_ack),
        .dmem_rdata (dmem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one access and play the memory side; returns in the DONE cycle with inputs dropped
    task automatic do_access(input logic rd, input logic wr, input logic [2:0] f3,
                             input logic [31:0] a, input logic [31:0] wd,
                             input int waits, input logic [31:0] rdata);
        int guard;
        int busy;
        mem_read  = rd;
        mem_write = wr;
        funct3    = f3;
        addr      = a;
        wdata     = wd;
        #1;
        stall_cnt = 0;
        busy      = 0;
        guard     = 0;
        stable_ok = 1'b1;
        while (stall && guard < 50) begin
            stall_cnt++;
            if (dmem_req) begin
                if (busy == 0) begin
                    cap_addr  = dmem_addr;
                    cap_wdata = dmem_wdata;
                    cap_wstrb = dmem_wstrb;
                    cap_we    = dmem_we;
                end else if (dmem_addr !== cap_addr || dmem_wdata !== cap_wdata ||
                             dmem_wstrb !== cap_wstrb || dmem_we !== cap_we) begin
                    stable_ok = 1'b0;
                end
                if (busy == waits) begin
                    dmem_ack   = 1'b1;
                    dmem_rdata = rdata;
                end
                busy++;
            end else if (busy > 0) begin
                stable_ok = 1'b0;
            end
            tick();
            dmem_ack = 1'b0;
            guard++;
        end
        if (guard >= 50) check("access_timeout", 32'(guard), 32'd0);
        mem_read  = 1'b0;
        mem_write = 1'b0;
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst        = 1'b1;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        funct3     = 3'd0;
        addr       = 32'd0;
        wdata      = 32'd0;
        dmem_ack   = 1'b0;
        dmem_rdata = 32'd0;
        tick();
        tick();
        rst = 1'b0;
        #1;

        // Reset state
        check("rst_req",   32'(dmem_req),   32'd0);
        check("rst_we",    32'(dmem_we),    32'd0);
        check("rst_addr",  dmem_addr,       32'd0);
        check("rst_wdata", dmem_wdata,      32'd0);
        check("rst_wstrb", 32'(dmem_wstrb), 32'd0);
        check("rst_ld",    load_data,       32'd0);
        check("rst_stall", 32'(stall),      32'd0);
        check("rst_fault", 32'(fault),      32'd0);

        // LW, ack in first BUSY cycle
        do_access(1'b1, 1'b0, 3'd2, 32'h100, 32'd0, 0, 32'h8000_00FF);
        check("lw_addr",  cap_addr,         32'h100);
        check("lw_we",    32'(cap_we),      32'd0);
        check("lw_wstrb", 32'(cap_wstrb),   32'd0);
        check("lw_stall", 32'(stall_cnt),   32'd2);
        check("lw_data",  load_data,        32'h8000_00FF);
        check("lw_req_done", 32'(dmem_req), 32'd0);
        tick();

        // Byte/half loads with sign and zero extension
        do_access(1'b1, 1'b0, 3'd0, 32'h103, 32'd0, 0, 32'h80FF_7F01);
        check("lb_103", load_data, 32'hFFFF_FF80);
        tick();
        do_access(1'b1, 1'b0, 3'd4, 32'h103, 32'd0, 0, 32'h80FF_7F01);
        check("lbu_103", load_data, 32'h0000_0080);
        tick();
        do_access(1'b1, 1'b0, 3'd1, 32'h102, 32'd0, 0, 32'h80FF_7F01);
        check("lh_102", load_data, 32'hFFFF_80FF);
        tick();
        do_access(1'b1, 1'b0, 3'd5, 32'h102, 32'd0, 0, 32'h80FF_7F01);
        check("lhu_102", load_data, 32'h0000_80FF);
        tick();
        do_access(1'b1, 1'b0, 3'd0, 32'h101, 32'd0, 0, 32'h80FF_7F01);
        check("lb_101", load_data, 32'h0000_007F);
        tick();
        do_access(1'b1, 1'b0, 3'd1, 32'h100, 32'd0, 0, 32'h80FF_7F01);
        check("lh_100", load_data, 32'h0000_7F01);
        tick();

        // SH to upper half; load_data must keep 0x00007F01
        do_access(1'b0, 1'b1, 3'd1, 32'h206, 32'h1234_ABCD, 0, 32'hFFFF_FFFF);
        check("sh_addr",  cap_addr,       32'h204);
        check("sh_wdata", cap_wdata,      32'hABCD_ABCD);
        check("sh_wstrb", 32'(cap_wstrb), 32'b1100);
        check("sh_we",    32'(cap_we),    32'd1);
        check("sh_ld",    load_data,      32'h0000_7F01);
        tick();

        // SW full word
        do_access(1'b0, 1'b1, 3'd2, 32'h200, 32'hDEAD_BEEF, 1, 32'd0);
        check("sw_wdata", cap_wdata,      32'hDEAD_BEEF);
        check("sw_wstrb", 32'(cap_wstrb), 32'b1111);
        check("sw_stall", 32'(stall_cnt), 32'd3);
        tick();

        // Misaligned SW: fault, no stall, no request over several cycles
        mem_write = 1'b1; funct3 = 3'd2; addr = 32'h101; wdata = 32'h5;
        #1;
        check("sw_mis_fault", 32'(fault), 32'd1);
        check("sw_mis_stall", 32'(stall), 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("sw_mis_req", 32'(dmem_req), 32'd0);
            check("sw_mis_idle", 32'(stall), 32'd0);
        end
        mem_write = 1'b0;

        // Illegal load funct3=3
        mem_read = 1'b1; funct3 = 3'd3; addr = 32'h100;
        #1;
        check("ld_f3_fault", 32'(fault), 32'd1);
        check("ld_f3_stall", 32'(stall), 32'd0);
        tick();
        check("ld_f3_req", 32'(dmem_req), 32'd0);

        // Other fault cases
        funct3 = 3'd1; addr = 32'h101; #1;
        check("lh_mis_fault", 32'(fault), 32'd1);
        funct3 = 3'd5; addr = 32'h102; #1;
        check("lhu_ok_fault", 32'(fault), 32'd0);
        mem_read = 1'b0; mem_write = 1'b1; funct3 = 3'd4; addr = 32'h100; #1;
        check("st_f3_fault", 32'(fault), 32'd1);
        mem_read = 1'b1; funct3 = 3'd2; #1;
        check("rdwr_fault", 32'(fault), 32'd1);
        mem_read = 1'b0; mem_write = 1'b0; funct3 = 3'd3; #1;
        check("noop_fault", 32'(fault), 32'd0);
        check("noop_stall", 32'(stall), 32'd0);
        tick();

        // LW with 5 wait cycles, then SB back-to-back
        do_access(1'b1, 1'b0, 3'd2, 32'h300, 32'd0, 5, 32'hCAFE_F00D);
        check("lwd_stall",  32'(stall_cnt), 32'd7);
        check("lwd_stable", 32'(stable_ok), 32'd1);
        check("lwd_addr",   cap_addr,       32'h300);
        check("lwd_data",   load_data,      32'hCAFE_F00D);
        mem_write = 1'b1; funct3 = 3'd0; addr = 32'h3; wdata = 32'h0000_00A5;
        #1;
        check("b2b_done_stall", 32'(stall), 32'd0);
        tick();
        check("b2b_idle_req",   32'(dmem_req), 32'd0);
        check("b2b_idle_stall", 32'(stall),    32'd1);
        do_access(1'b0, 1'b1, 3'd0, 32'h3, 32'h0000_00A5, 0, 32'd0);
        check("sb_addr",  cap_addr,       32'h0);
        check("sb_wstrb", 32'(cap_wstrb), 32'b1000);
        check("sb_wdata", cap_wdata,      32'hA5A5_A5A5);
        check("sb_ld",    load_data,      32'hCAFE_F00D);
        tick();

        // Reset during 2nd BUSY cycle with ack present; op held
        mem_read = 1'b1; mem_write = 1'b0; funct3 = 3'd2; addr = 32'h400;
        #1;
        check("rb_stall0", 32'(stall), 32'd1);
        tick();
        check("rb_req1", 32'(dmem_req), 32'd1);
        tick();
        dmem_ack = 1'b1; dmem_rdata = 32'h1111_2222; rst = 1'b1;
        tick();
        dmem_ack = 1'b0; rst = 1'b0;
        #1;
        check("rb_req",   32'(dmem_req), 32'd0);
        check("rb_ld",    load_data,     32'd0);
        check("rb_stall", 32'(stall),    32'd1);
        tick();
        check("rb_restart_req",  32'(dmem_req), 32'd1);
        check("rb_restart_addr", dmem_addr,     32'h400);
        dmem_ack = 1'b1; dmem_rdata = 32'h1234_5678;
        tick();
        dmem_ack = 1'b0;
        mem_read = 1'b0;
        #1;
        check("rb_done_ld",    load_data,     32'h1234_5678);
        check("rb_done_stall", 32'(stall),    32'd0);
        tick();

        // Stray ack in IDLE is ignored
        dmem_ack = 1'b1; dmem_rdata = 32'hFFFF_FFFF;
        tick();
        dmem_ack = 1'b0;
        #1;
        check("stray_ack_ld",  load_data,     32'h1234_5678);
        check("stray_ack_req", 32'(dmem_req), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
